// File: rtl/aw_queue_mc_pkg.sv
// Shared types for the multi-channel AW buffer: the stored AW entry and
// the arbitration mode constants.
package aw_pkg;

    localparam int AW_ID_W   = 4;
    localparam int AW_ADDR_W = 32;
    localparam int AW_LEN_W  = 4;
    localparam int AW_SIZE_W = 3;

    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;

    typedef struct packed {
        logic [AW_ID_W-1:0]   id;
        logic [AW_ADDR_W-1:0] addr;
        logic [AW_LEN_W-1:0]  len;
        logic [AW_SIZE_W-1:0] size;
        logic [1:0]           burst;
    } aw_entry_t;

    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/aw_queue_mc_if.sv
// Bundle of the per-channel upstream AW inputs, the merged downstream AW
// stream and the per-queue occupancy.
interface aw_queue_mc_if #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 4,
    parameter int SIZE_WIDTH = 3,
    parameter int NUM_CH     = 4,
    parameter int DEPTH      = 8
);
    import aw_pkg::*;

    localparam int CH_W  = ch_width(NUM_CH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [NUM_CH-1:0]            s_awvalid;
    logic [NUM_CH-1:0]            s_awready;
    logic [NUM_CH*ID_WIDTH-1:0]   s_awid;
    logic [NUM_CH*ADDR_WIDTH-1:0] s_awaddr;
    logic [NUM_CH*LEN_WIDTH-1:0]  s_awlen;
    logic [NUM_CH*SIZE_WIDTH-1:0] s_awsize;
    logic [NUM_CH*2-1:0]          s_awburst;

    logic                         m_awvalid;
    logic                         m_awready;
    logic [CH_W+ID_WIDTH-1:0]     m_awid;
    logic [ADDR_WIDTH-1:0]        m_awaddr;
    logic [LEN_WIDTH-1:0]         m_awlen;
    logic [SIZE_WIDTH-1:0]        m_awsize;
    logic [1:0]                   m_awburst;
    logic [CH_W-1:0]              m_ch;
    logic [NUM_CH*CNT_W-1:0]      occupancy;

    modport slave (
        input  s_awvalid, s_awid, s_awaddr, s_awlen, s_awsize, s_awburst, m_awready,
        output s_awready, m_awvalid, m_awid, m_awaddr, m_awlen, m_awsize, m_awburst,
               m_ch, occupancy
    );

    modport master (
        output s_awvalid, s_awid, s_awaddr, s_awlen, s_awsize, s_awburst, m_awready,
        input  s_awready, m_awvalid, m_awid, m_awaddr, m_awlen, m_awsize, m_awburst,
               m_ch, occupancy
    );

endinterface

// File: rtl/aw_sync_fifo.sv
// Single-clock FIFO with a combinational head output; storage is not reset,
// only pointers and count are.
module aw_sync_fifo #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [DATA_W-1:0]          data_i,
    input  logic                       pop_i,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic [DATA_W-1:0]          head_o
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              push_ok, pop_ok;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + 1'b1;
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/aw_queue_mc.sv
// NUM_CH independent AW queues merged into one AW stream by a round-robin or
// fixed-priority arbiter; the source channel is prepended to AWID.
module aw_queue_mc
    import aw_pkg::*;
#(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 4,
    parameter int SIZE_WIDTH = 3,
    parameter int NUM_CH     = 4,
    parameter int DEPTH      = 8,
    parameter int ARB_MODE   = ARB_RR
) (
    input  logic           clk,
    input  logic           rst,
    aw_queue_mc_if.slave   bus
);
    localparam int CH_W  = ch_width(NUM_CH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef logic [CH_W-1:0] ch_t;

    logic [NUM_CH-1:0]       full, empty, push, pop, s_rdy;
    logic [NUM_CH*CNT_W-1:0] occ;
    aw_entry_t               head  [NUM_CH];
    logic [CNT_W-1:0]        count [NUM_CH];

    ch_t       rr_ptr_q, rr_ptr_d;
    ch_t       hold_ch_q, hold_ch_d;
    logic      hold_vld_q, hold_vld_d;
    ch_t       arb_ch, grant_ch;
    logic      found;
    int        idx;
    logic      any_ne, m_vld, pop_any;
    aw_entry_t sel;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        aw_entry_t wr_entry;

        assign wr_entry.id    = bus.s_awid[i*ID_WIDTH +: ID_WIDTH];
        assign wr_entry.addr  = bus.s_awaddr[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign wr_entry.len   = bus.s_awlen[i*LEN_WIDTH +: LEN_WIDTH];
        assign wr_entry.size  = bus.s_awsize[i*SIZE_WIDTH +: SIZE_WIDTH];
        assign wr_entry.burst = bus.s_awburst[i*2 +: 2];

        aw_sync_fifo #(
            .DEPTH  (DEPTH),
            .DATA_W ($bits(aw_entry_t))
        ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .push_i  (push[i]),
            .data_i  (wr_entry),
            .pop_i   (pop[i]),
            .full_o  (full[i]),
            .empty_o (empty[i]),
            .count_o (count[i]),
            .head_o  (head[i])
        );
    end

    always_comb begin
        s_rdy = '0;
        push  = '0;
        pop   = '0;
        occ   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            s_rdy[i] = !full[i] && !rst;
            push[i]  = bus.s_awvalid[i] && s_rdy[i];
            pop[i]   = pop_any && (grant_ch == ch_t'(i));
            occ[i*CNT_W +: CNT_W] = count[i];
        end
    end

    // Arbitration: search for the first non-empty queue
    always_comb begin
        arb_ch = '0;
        found  = 1'b0;
        idx    = 0;
        if (ARB_MODE == ARB_FIXED) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (!found && !empty[i]) begin
                    arb_ch = ch_t'(i);
                    found  = 1'b1;
                end
            end
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                idx = int'(rr_ptr_q) + k;
                if (idx >= NUM_CH) idx = idx - NUM_CH;
                if (!found && !empty[idx]) begin
                    arb_ch = ch_t'(idx);
                    found  = 1'b1;
                end
            end
        end
    end

    // A stalled grant is held so a newly filled higher-priority queue cannot steal it
    assign grant_ch = hold_vld_q ? hold_ch_q : arb_ch;
    assign any_ne   = |(~empty);
    assign m_vld    = any_ne && !rst;
    assign pop_any  = m_vld && bus.m_awready;
    assign sel      = head[grant_ch];

    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        if (pop_any) begin
            rr_ptr_d = (grant_ch == ch_t'(NUM_CH - 1)) ? '0 : grant_ch + 1'b1;
        end
        hold_vld_d = m_vld && !bus.m_awready;
        hold_ch_d  = grant_ch;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q   <= '0;
            hold_vld_q <= 1'b0;
            hold_ch_q  <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            hold_vld_q <= hold_vld_d;
            hold_ch_q  <= hold_ch_d;
        end
    end

    // Fields are forced to zero when idle so stale storage never leaks out
    assign bus.s_awready = s_rdy;
    assign bus.occupancy = occ;
    assign bus.m_awvalid = m_vld;
    assign bus.m_ch      = m_vld ? grant_ch : '0;
    assign bus.m_awid    = m_vld ? {grant_ch, sel.id} : '0;
    assign bus.m_awaddr  = m_vld ? sel.addr : '0;
    assign bus.m_awlen   = m_vld ? sel.len : '0;
    assign bus.m_awsize  = m_vld ? sel.size : '0;
    assign bus.m_awburst = m_vld ? sel.burst : '0;

endmodule

// File: tb/tb_aw_queue_mc.sv
// Directed bench for aw_queue_mc with a channel-aware scoreboard checked by a
// monitor on every downstream handshake.
module tb_aw_queue_mc;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    aw_queue_mc_if #(.NUM_CH(4), .DEPTH(8)) bus ();

    aw_queue_mc #(.NUM_CH(4), .DEPTH(8), .ARB_MODE(0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int         ch;
        logic [3:0]  id;
        logic [31:0] addr;
        logic [3:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } item_t;

    item_t sb[$];
    int    ch_seq[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    n_pop    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] occ(input int ch);
        return bus.occupancy[ch*4 +: 4];
    endfunction

    task automatic push1(input int ch, input logic [3:0] id, input logic [31:0] addr,
                         input logic [3:0] len, input bit exp_acc);
        item_t it;
        bus.s_awvalid[ch]          = 1'b1;
        bus.s_awid[ch*4 +: 4]      = id;
        bus.s_awaddr[ch*32 +: 32]  = addr;
        bus.s_awlen[ch*4 +: 4]     = len;
        bus.s_awsize[ch*3 +: 3]    = id[2:0];
        bus.s_awburst[ch*2 +: 2]   = 2'b01;
        @(negedge clk);
        chk($sformatf("s_awready_ch%0d", ch), 64'(bus.s_awready[ch]), 64'(exp_acc));
        if (exp_acc) begin
            it = '{ch, id, addr, len, id[2:0], 2'b01};
            sb.push_back(it);
        end
        @(posedge clk);
        #1;
        bus.s_awvalid[ch] = 1'b0;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.s_awvalid = '0;
        bus.m_awready = 1'b0;
        sb.delete();
        ch_seq.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    always @(negedge clk) begin : monitor
        int    hit;
        item_t e;
        if (!rst && bus.m_awvalid && bus.m_awready) begin
            hit = -1;
            n_pop++;
            for (int i = 0; i < sb.size(); i++) begin
                if (hit < 0 && sb[i].ch == int'(bus.m_ch)) hit = i;
            end
            if (hit < 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got ch %0d addr 0x%0h, expected no output",
                         bus.m_ch, bus.m_awaddr);
            end else begin
                e = sb[hit];
                chk("m_awid",    64'(bus.m_awid),    64'({e.ch[1:0], e.id}));
                chk("m_awaddr",  64'(bus.m_awaddr),  64'(e.addr));
                chk("m_awlen",   64'(bus.m_awlen),   64'(e.len));
                chk("m_awsize",  64'(bus.m_awsize),  64'(e.size));
                chk("m_awburst", 64'(bus.m_awburst), 64'(e.burst));
                sb.delete(hit);
            end
            if (ch_seq.size() > 0) begin
                chk("m_ch_order", 64'(bus.m_ch), 64'(ch_seq.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.s_awvalid = '0;
        bus.s_awid    = '1;
        bus.s_awaddr  = '1;
        bus.s_awlen   = '1;
        bus.s_awsize  = '1;
        bus.s_awburst = '1;
        bus.m_awready = 1'b0;

        // Reset with every channel requesting
        bus.s_awvalid = 4'hF;
        @(posedge clk);
        repeat (3) begin
            @(negedge clk);
            chk("rst_s_awready", 64'(bus.s_awready), 64'h0);
            chk("rst_m_awvalid", 64'(bus.m_awvalid), 64'h0);
            chk("rst_occupancy", 64'(bus.occupancy), 64'h0);
            chk("rst_m_ch",      64'(bus.m_ch),      64'h0);
        end
        @(posedge clk);
        #1;
        rst           = 1'b0;
        bus.s_awvalid = '0;
        bus.m_awready = 1'b1;
        push1(0, 4'hA, 32'h0000_00A0, 4'h1, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        chk("post_rst_occ0", 64'(occ(0)), 64'h0);
        chk("post_rst_sb_empty", 64'(sb.size()), 64'h0);

        // Single entry through ch2
        do_reset();
        push1(2, 4'h5, 32'h0000_1000, 4'h3, 1'b1);
        chk("single_m_awvalid", 64'(bus.m_awvalid), 64'h1);
        chk("single_m_ch",      64'(bus.m_ch),      64'h2);
        chk("single_m_awid",    64'(bus.m_awid),    64'h25);
        chk("single_m_awaddr",  64'(bus.m_awaddr),  64'h1000);
        chk("single_occ2",      64'(occ(2)),        64'h1);
        bus.m_awready = 1'b1;
        @(posedge clk);
        #1;
        bus.m_awready = 1'b0;
        chk("single_occ2_after", 64'(occ(2)), 64'h0);
        chk("single_m_awvalid_after", 64'(bus.m_awvalid), 64'h0);
        chk("single_sb_empty", 64'(sb.size()), 64'h0);

        // Fill ch0 and try to overflow it
        do_reset();
        for (int k = 0; k < 8; k++) begin
            push1(0, 4'(k), 32'h2000 + 32'(k * 16), 4'(k), 1'b1);
        end
        chk("fill_occ0", 64'(occ(0)), 64'h8);
        chk("fill_ready0", 64'(bus.s_awready[0]), 64'h0);
        push1(0, 4'hF, 32'h0000_DEAD, 4'h0, 1'b0);
        chk("overflow_occ0", 64'(occ(0)), 64'h8);
        bus.m_awready = 1'b1;
        @(posedge clk);
        #1;
        bus.m_awready = 1'b0;
        chk("refill_ready0", 64'(bus.s_awready[0]), 64'h1);
        chk("refill_occ0",   64'(occ(0)), 64'h7);
        bus.m_awready = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        bus.m_awready = 1'b0;
        chk("fill_drained_occ0", 64'(occ(0)), 64'h0);
        chk("fill_sb_empty", 64'(sb.size()), 64'h0);

        // Round-robin drain of two entries per queue
        do_reset();
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 2; k++) begin
                push1(c, 4'(c * 2 + k), 32'(c * 256 + k * 4), 4'(k), 1'b1);
            end
        end
        ch_seq = '{0, 1, 2, 3, 0, 1, 2, 3};
        n_pop  = 0;
        bus.m_awready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        bus.m_awready = 1'b0;
        chk("rr_pops_in_8_cycles", 64'(n_pop), 64'h8);
        chk("rr_m_awvalid_end", 64'(bus.m_awvalid), 64'h0);
        chk("rr_sb_empty", 64'(sb.size()), 64'h0);

        // Stalled grant on ch3 must survive a push into ch0
        do_reset();
        push1(3, 4'h7, 32'h0000_3000, 4'h2, 1'b1);
        push1(0, 4'h1, 32'h0000_0100, 4'h0, 1'b1);
        chk("stall_m_ch",     64'(bus.m_ch),     64'h3);
        chk("stall_m_awid",   64'(bus.m_awid),   64'h37);
        chk("stall_m_awaddr", 64'(bus.m_awaddr), 64'h3000);
        chk("stall_m_awlen",  64'(bus.m_awlen),  64'h2);
        repeat (2) @(posedge clk);
        #1;
        chk("stall_m_ch_later",     64'(bus.m_ch),     64'h3);
        chk("stall_m_awaddr_later", 64'(bus.m_awaddr), 64'h3000);
        ch_seq = '{3, 0};
        bus.m_awready = 1'b1;
        @(posedge clk);
        #1;
        chk("stall_next_m_ch",     64'(bus.m_ch),     64'h0);
        chk("stall_next_m_awaddr", 64'(bus.m_awaddr), 64'h100);
        @(posedge clk);
        #1;
        bus.m_awready = 1'b0;
        chk("stall_sb_empty", 64'(sb.size()), 64'h0);
        chk("stall_m_awvalid_end", 64'(bus.m_awvalid), 64'h0);

        // Concurrent push and pop on ch1
        do_reset();
        for (int k = 0; k < 4; k++) begin
            push1(1, 4'(k), 32'h4000 + 32'(k * 4), 4'(k), 1'b1);
        end
        bus.m_awready = 1'b1;
        for (int j = 0; j < 10; j++) begin
            push1(1, 4'(4 + j), 32'h4100 + 32'(j * 4), 4'(j), 1'b1);
            chk($sformatf("pushpop_occ1_%0d", j), 64'(occ(1)), 64'h4);
        end
        repeat (4) @(posedge clk);
        #1;
        bus.m_awready = 1'b0;
        chk("pushpop_occ1_end", 64'(occ(1)), 64'h0);
        chk("pushpop_sb_empty", 64'(sb.size()), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
